// File: rtl/am_eval_pkg.sv
// Shared types and width helpers for the approximate-multiplier error monitor.
package am_eval_pkg;

  localparam int unsigned DefaultW           = 8;
  localparam int unsigned DefaultSamplesLog2 = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StDone
  } am_state_e;

  // Worst-case ED (2^2W - 1) times N samples fits exactly in 2W + log2(N) bits.
  function automatic int unsigned sum_ed_width(input int unsigned w,
                                               input int unsigned samples_log2);
    return 2 * w + samples_log2;
  endfunction

  function automatic int unsigned sum_sq_width(input int unsigned w,
                                               input int unsigned samples_log2);
    return 4 * w + samples_log2;
  endfunction

  // Counters must reach N itself, not just N-1.
  function automatic int unsigned cnt_width(input int unsigned samples_log2);
    return samples_log2 + 1;
  endfunction

endpackage

// File: rtl/am_ed_calc.sv
// Two-stage error-distance pipeline: S1 holds the exact product, S2 holds |exact - z|.
// With AM_ERR_SQ_EN defined, S2 also registers ed*ed.
module am_ed_calc #(
  parameter int unsigned W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  input  logic [W-1:0]   x_i,
  input  logic [W-1:0]   y_i,
  input  logic [2*W-1:0] z_i,
  output logic           s1_valid_o,
  output logic           s2_valid_o,
`ifdef AM_ERR_SQ_EN
  output logic [4*W-1:0] ed_sq_o,
`endif
  output logic [2*W-1:0] ed_o
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] exact_q, z_q, ed_q;
  logic          s1_valid_q, s2_valid_q;
  logic [PW:0]   diff, diff_neg;
  logic [PW-1:0] abs_diff;

  // One extra bit so z > exact shows up as a negative difference.
  always_comb begin
    diff     = {1'b0, exact_q} - {1'b0, z_q};
    diff_neg = -diff;
    abs_diff = diff[PW] ? diff_neg[PW-1:0] : diff[PW-1:0];
  end

`ifdef AM_ERR_SQ_EN
  logic [4*W-1:0] ed_sq_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exact_q    <= '0;
      z_q        <= '0;
      ed_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
`ifdef AM_ERR_SQ_EN
      ed_sq_q    <= '0;
`endif
    end else begin
      s1_valid_q <= in_valid_i;
      s2_valid_q <= s1_valid_q;
      if (in_valid_i) begin
        exact_q <= PW'(x_i) * PW'(y_i);
        z_q     <= z_i;
      end
      if (s1_valid_q) begin
        ed_q    <= abs_diff;
`ifdef AM_ERR_SQ_EN
        ed_sq_q <= (4 * W)'(abs_diff) * (4 * W)'(abs_diff);
`endif
      end
    end
  end

  assign s1_valid_o = s1_valid_q;
  assign s2_valid_o = s2_valid_q;
  assign ed_o       = ed_q;
`ifdef AM_ERR_SQ_EN
  assign ed_sq_o    = ed_sq_q;
`endif

endmodule

// File: rtl/am_error_monitor.sv
// Approximate-multiplier error monitor: windowed ED sum, max ED and error count.
// Define AM_ERR_SQ_EN to add the squared-error accumulator output sum_sq_ed.
module am_error_monitor
  import am_eval_pkg::*;
#(
  parameter int unsigned W            = DefaultW,
  parameter int unsigned SAMPLES_LOG2 = DefaultSamplesLog2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [W-1:0]                              x,
  input  logic [W-1:0]                              y,
  input  logic [2*W-1:0]                            z,
  output logic                                      busy,
  output logic                                      res_valid,
  input  logic                                      res_ready,
  output logic [sum_ed_width(W, SAMPLES_LOG2)-1:0]  sum_ed,
  output logic [2*W-1:0]                            max_ed,
  output logic [cnt_width(SAMPLES_LOG2)-1:0]        err_cnt,
`ifdef AM_ERR_SQ_EN
  output logic [sum_sq_width(W, SAMPLES_LOG2)-1:0]  sum_sq_ed,
`endif
  output logic [cnt_width(SAMPLES_LOG2)-1:0]        sample_cnt
);

  localparam int unsigned PW   = 2 * W;
  localparam int unsigned SumW = sum_ed_width(W, SAMPLES_LOG2);
  localparam int unsigned CntW = cnt_width(SAMPLES_LOG2);
  localparam logic [CntW-1:0] LastIdx = CntW'(2 ** SAMPLES_LOG2 - 1);

  am_state_e       state_q;
  logic [CntW-1:0] issued_q;
  logic            accept, clear;
  logic            s1_valid, ed_valid;
  logic [PW-1:0]   ed;

  logic [SumW-1:0] sum_ed_q;
  logic [PW-1:0]   max_ed_q;
  logic [CntW-1:0] err_cnt_q, sample_cnt_q;

  assign in_ready  = (state_q == StAccum);
  assign busy      = (state_q == StAccum) || (state_q == StDrain);
  assign res_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign clear     = (state_q == StIdle) && start;

`ifdef AM_ERR_SQ_EN
  localparam int unsigned SqW = sum_sq_width(W, SAMPLES_LOG2);
  logic [4*W-1:0] ed_sq;
  logic [SqW-1:0] sum_sq_q;
`endif

  am_ed_calc #(
    .W (W)
  ) u_ed_calc (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (accept),
    .x_i        (x),
    .y_i        (y),
    .z_i        (z),
    .s1_valid_o (s1_valid),
    .s2_valid_o (ed_valid),
`ifdef AM_ERR_SQ_EN
    .ed_sq_o    (ed_sq),
`endif
    .ed_o       (ed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      issued_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StAccum;
            issued_q <= '0;
          end
        end
        StAccum: begin
          if (accept) begin
            issued_q <= issued_q + 1'b1;
            if (issued_q == LastIdx) state_q <= StDrain;
          end
        end
        // Accumulators settle the edge after S2 empties, before DONE is entered.
        StDrain: if (!s1_valid && !ed_valid) state_q <= StDone;
        StDone:  if (res_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
      err_cnt_q    <= '0;
      sample_cnt_q <= '0;
`ifdef AM_ERR_SQ_EN
      sum_sq_q     <= '0;
`endif
    end else if (clear) begin
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
      err_cnt_q    <= '0;
      sample_cnt_q <= '0;
`ifdef AM_ERR_SQ_EN
      sum_sq_q     <= '0;
`endif
    end else if (ed_valid) begin
      sum_ed_q     <= sum_ed_q + SumW'(ed);
      sample_cnt_q <= sample_cnt_q + 1'b1;
      if (ed > max_ed_q) max_ed_q <= ed;
      if (ed != '0) err_cnt_q <= err_cnt_q + 1'b1;
`ifdef AM_ERR_SQ_EN
      sum_sq_q     <= sum_sq_q + SqW'(ed_sq);
`endif
    end
  end

  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;
  assign err_cnt    = err_cnt_q;
  assign sample_cnt = sample_cnt_q;
`ifdef AM_ERR_SQ_EN
  assign sum_sq_ed  = sum_sq_q;
`endif

endmodule

// File: tb/tb_am_error_monitor.sv
// Self-checking bench for am_error_monitor (W=8, N=16) against a sample-list reference model.
// Honours AM_ERR_SQ_EN for the squared-error output.
module tb_am_error_monitor;

  localparam int unsigned W  = 8;
  localparam int unsigned SL = 4;
  localparam int unsigned N  = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
  logic in_ready, busy, res_valid;
  logic [W-1:0]      x = '0, y = '0;
  logic [2*W-1:0]    z = '0;
  logic [2*W+SL-1:0] sum_ed;
  logic [2*W-1:0]    max_ed;
  logic [SL:0]       err_cnt, sample_cnt;
`ifdef AM_ERR_SQ_EN
  logic [4*W+SL-1:0] sum_sq_ed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: statistics over the first N offered samples of the window.
  longint unsigned m_sum, m_sq;
  int unsigned     m_max, m_err, m_cnt;
  int unsigned     qx[$], qy[$], qz[$];

  always #5 clk = ~clk;

  am_error_monitor #(
    .W            (W),
    .SAMPLES_LOG2 (SL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .z          (z),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .err_cnt    (err_cnt),
`ifdef AM_ERR_SQ_EN
    .sum_sq_ed  (sum_sq_ed),
`endif
    .sample_cnt (sample_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = 0; m_sq = 0; m_max = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_add(input int unsigned a, input int unsigned b, input int unsigned c);
    int unsigned p, e;
    if (m_cnt < N) begin
      p = a * b;
      e = (p >= c) ? p - c : c - p;
      m_sum += e;
      m_sq  += longint'(e) * longint'(e);
      if (e > m_max) m_max = e;
      if (e != 0) m_err++;
      m_cnt++;
    end
  endtask

  task automatic push(input int unsigned a, input int unsigned b, input int unsigned c);
    qx.push_back(a); qy.push_back(b); qz.push_back(c);
  endtask

  // mode 0 exact, 1 truncated low nibble, 2 random, 3 overshoot (z > exact)
  task automatic push_rand(input int unsigned mode);
    int unsigned a, b, p, c;
    a = $urandom_range(255);
    b = $urandom_range(255);
    p = a * b;
    case (mode)
      0: c = p;
      1: c = p & 32'hFFF0;
      2: c = $urandom_range(65535);
      default: c = p + 7;
    endcase
    push(a, b, c);
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
  endtask

  // Offers every queued sample once; in_ready must be high exactly while fewer than N are taken.
  task automatic feed(input int unsigned gap_pct);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < qx.size() && guard < 500) begin
      guard++;
      check("in_ready", {63'd0, in_ready}, {63'd0, m_cnt < N});
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        x = W'(qx[i]);
        y = W'(qy[i]);
        z = (2 * W)'(qz[i]);
        model_add(qx[i], qy[i], qz[i]);
        i++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (guard >= 500) check("feed_timeout", 64'd0, 64'd1);
    qx.delete(); qy.delete(); qz.delete();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!res_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("res_valid_rise", {63'd0, res_valid}, 64'd1);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_sum_ed"}, 64'(sum_ed), m_sum);
    check({tag, "_max_ed"}, 64'(max_ed), 64'(m_max));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(m_err));
    check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'(m_cnt));
`ifdef AM_ERR_SQ_EN
    check({tag, "_sum_sq_ed"}, 64'(sum_sq_ed), m_sq);
`endif
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_res_valid_drop"}, {63'd0, res_valid}, 64'd0);
    check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
    check_results({tag, "_retained"});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
    check({tag, "_sum_ed"}, 64'(sum_ed), 64'd0);
    check({tag, "_max_ed"}, 64'(max_ed), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
`ifdef AM_ERR_SQ_EN
    check({tag, "_sum_sq_ed"}, 64'(sum_sq_ed), 64'd0);
`endif
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();

    // Exact multiplier: no error at all.
    do_start();
    check("accum_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 16; i++) push_rand(0);
    feed(0);
    wait_done();
    check_results("exact");
    check("exact_sum_zero", 64'(sum_ed), 64'd0);
    check("exact_cnt_n", 64'(sample_cnt), 64'(N));
    handshake("exact");

    // Two known errors among exact samples.
    do_start();
    push(255, 255, 0);
    push(3, 5, 20);
    for (int i = 0; i < 14; i++) push_rand(0);
    feed(30);
    wait_done();
    check("known_sum_ed", 64'(sum_ed), 64'd65030);
    check("known_max_ed", 64'(max_ed), 64'd65025);
    check("known_err_cnt", 64'(err_cnt), 64'd2);
`ifdef AM_ERR_SQ_EN
    check("known_sum_sq_ed", 64'(sum_sq_ed), 64'd4228250650);
`endif
    check_results("known");
    handshake("known");

    // 20 offers with gaps: only 16 taken; result held under res_ready=0, start ignored in DONE.
    do_start();
    for (int i = 0; i < 20; i++) push_rand($urandom_range(3));
    feed(40);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    wait_done();
    check("bp_cnt_n", 64'(sample_cnt), 64'(N));
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(posedge clk); #1;
      start = 1'b0;
      check("bp_hold_valid", {63'd0, res_valid}, 64'd1);
      check_results("bp_hold");
    end
    handshake("bp");

    // Asynchronous reset mid-window abandons the partial result.
    do_start();
    for (int i = 0; i < 7; i++) push_rand(2);
    feed(0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_start();
    for (int i = 0; i < 16; i++) push_rand($urandom_range(3));
    feed(20);
    wait_done();
    check_results("after_rst");
    handshake("after_rst");

    // Random windows, mixed error modes and gap densities.
    for (int w = 0; w < 6; w++) begin
      do_start();
      for (int i = 0; i < 16 + $urandom_range(4); i++) push_rand($urandom_range(3));
      feed($urandom_range(50));
      wait_done();
      check_results("rand");
      handshake("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
